// File: rtl/adc_capture_controller.sv
// adc_capture_controller
// Captures a programmed number of ADC beats, starting at a programmed
// timestamp, into a 64-beat buffer. The buffer is read back as half-width
// words, low half first.
//
// Handshake: the ADC slave is always ready once out of reset, so a beat
// transfers on every cycle where s00_axis_tvalid=1. The read port uses
// valid/ready: a word transfers on a clock edge where rd_valid && rd_ready.
// rd_data is stable while rd_valid=1 and rd_ready=0.
module adc_capture_controller #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int OUT_WIDTH       = 128,
    parameter int DEPTH_LEN       = 6,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic [63:0]                counter,
    input  logic                       auto_start,
    input  logic                       arm,
    input  logic [63:0]                start_time,
    input  logic [COUNT_WIDTH-1:0]     sample_count,
    input  logic                       flush,
    input  logic                       rd_ready,
    output logic [OUT_WIDTH-1:0]       rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow_error,
    output logic                       timestamp_error,
    output logic [1:0]                 fsm_state
);

    localparam int DEPTH = 1 << DEPTH_LEN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [AXIS_DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LEN:0]         wr_ptr, rd_ptr;
    logic                       half;
    logic [COUNT_WIDTH-1:0]     beats_left;
    logic [63:0]                start_q;
    logic                       tready_q;

    logic match, late, arm_ok, capture_cycle, wr_try, wr_en, rd_fire;
    logic empty, full_i;

    // Timing qualifiers and buffer handshake decodes
    always_comb begin
        match         = auto_start && (counter == start_q);
        late          = counter > start_q;
        arm_ok        = arm && (sample_count != '0) && (state == IDLE || state == DONE);
        capture_cycle = (state == ARMED && match) || (state == CAPTURE);
        empty         = (wr_ptr == rd_ptr);
        full_i        = (wr_ptr[DEPTH_LEN] != rd_ptr[DEPTH_LEN]) &&
                        (wr_ptr[DEPTH_LEN-1:0] == rd_ptr[DEPTH_LEN-1:0]);
        // Fullness is judged before any same-cycle pop.
        wr_try        = capture_cycle && s00_axis_tvalid;
        wr_en         = wr_try && !full_i && !flush;
        rd_fire       = !empty && rd_ready && !flush;
    end

    // State register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (arm_ok) state_next = ARMED;
            ARMED: begin
                if (match)     state_next = (beats_left == COUNT_WIDTH'(1)) ? DONE : CAPTURE;
                else if (late) state_next = IDLE;
            end
            CAPTURE: if (beats_left == COUNT_WIDTH'(1)) state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Outputs decoded from state and registered pointers
    always_comb begin
        busy            = (state == ARMED) || (state == CAPTURE);
        done            = (state == DONE);
        full            = full_i;
        rd_valid        = !empty;
        rd_data         = half ? mem[rd_ptr[DEPTH_LEN-1:0]][OUT_WIDTH +: OUT_WIDTH]
                               : mem[rd_ptr[DEPTH_LEN-1:0]][0 +: OUT_WIDTH];
        s00_axis_tready = tready_q;
        fsm_state       = state;
    end

    // Control datapath: pointers, counters, sticky errors
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            half            <= 1'b0;
            beats_left      <= '0;
            start_q         <= '0;
            overflow_error  <= 1'b0;
            timestamp_error <= 1'b0;
            tready_q        <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (flush) begin
                wr_ptr          <= '0;
                rd_ptr          <= '0;
                half            <= 1'b0;
                beats_left      <= '0;
                overflow_error  <= 1'b0;
                timestamp_error <= 1'b0;
            end else begin
                if (arm_ok) begin
                    start_q    <= start_time;
                    beats_left <= sample_count;
                end
                // Capture counts cycles, not beats, to stay time-aligned.
                if (capture_cycle) beats_left <= beats_left - COUNT_WIDTH'(1);
                if (state == ARMED && !match && late) timestamp_error <= 1'b1;
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (wr_try && full_i) overflow_error <= 1'b1;
                if (rd_fire) begin
                    half <= !half;
                    if (half) rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Buffer storage write
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LEN-1:0]] <= s00_axis_tdata;
    end

endmodule

// File: tb/tb_adc_capture_controller.sv
// Directed bench for adc_capture_controller with a queue-based read checker.
module tb_adc_capture_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] tdata;
    logic         tvalid;
    logic         tready;
    logic [63:0]  counter;
    logic         auto_start;
    logic         arm;
    logic [63:0]  start_time;
    logic [15:0]  sample_count;
    logic         flush;
    logic         rd_ready;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         full;
    logic         busy;
    logic         done;
    logic         overflow_error;
    logic         timestamp_error;
    logic [1:0]   fsm_state;

    logic [127:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    adc_capture_controller dut (
        .s_axi_aclk      (clk),
        .s_axi_aresetn   (rst_n),
        .s00_axis_tdata  (tdata),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .counter         (counter),
        .auto_start      (auto_start),
        .arm             (arm),
        .start_time      (start_time),
        .sample_count    (sample_count),
        .flush           (flush),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .full            (full),
        .busy            (busy),
        .done            (done),
        .overflow_error  (overflow_error),
        .timestamp_error (timestamp_error),
        .fsm_state       (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Beat payload: low half = c, high half = c + 65536
    function automatic logic [255:0] mk(int c);
        return {128'(c + 65536), 128'(c)};
    endfunction

    task automatic push_beat(int c);
        exp_q.push_back(128'(c));
        exp_q.push_back(128'(c + 65536));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_arm(longint st, int cnt, longint cur);
        arm          = 1'b1;
        start_time   = 64'(st);
        sample_count = 16'(cnt);
        counter      = 64'(cur);
        tick();
        arm = 1'b0;
    endtask

    // Read out until the expected queue is drained, within a cycle budget
    task automatic drain(string name);
        rd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        rd_ready = 1'b0;
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s_drain: %0d words left, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        chk({name, "_empty_after"}, 128'(rd_valid), 128'(0));
    endtask

    // Monitor: compare each accepted read word against the queue head
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL rd_unexpected: got %0h, required no word", rd_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    err_cnt++;
                    $display("FAIL rd_data: got %0h required %0h", rd_data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; tdata = '0; tvalid = 1'b0; counter = '0; auto_start = 1'b1;
        arm = 1'b0; start_time = '0; sample_count = '0; flush = 1'b0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 128'(tready), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        chk("tready_after_release", 128'(tready), 128'(1));

        // 1: basic capture of 4 beats at t=100
        do_arm(100, 4, 95);
        chk("t1_busy", 128'(busy), 128'(1));
        for (int c = 96; c <= 110; c++) begin
            counter = 64'(c); tvalid = 1'b1; tdata = mk(c);
            if (c >= 100 && c <= 103) push_beat(c);
            tick();
            if (c == 102) chk("t1_done_early", 128'(done), 128'(0));
            if (c == 103) chk("t1_done", 128'(done), 128'(1));
        end
        tvalid = 1'b0;
        drain("t1");

        // 2: late target raises timestamp_error
        do_arm(50, 5, 60);
        tick();
        chk("t2_ts_error", 128'(timestamp_error), 128'(1));
        chk("t2_busy", 128'(busy), 128'(0));
        chk("t2_rd_valid", 128'(rd_valid), 128'(0));
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_ts_cleared", 128'(timestamp_error), 128'(0));

        // 3: 70 beats into 64-deep buffer, no reads
        do_arm(200, 70, 199);
        for (int c = 200; c <= 269; c++) begin
            counter = 64'(c); tvalid = 1'b1; tdata = mk(c);
            if (c <= 263) push_beat(c);
            tick();
            if (c == 262) chk("t3_not_full", 128'(full), 128'(0));
            if (c == 263) chk("t3_full", 128'(full), 128'(1));
            if (c == 263) chk("t3_no_ovf_yet", 128'(overflow_error), 128'(0));
            if (c == 264) chk("t3_ovf", 128'(overflow_error), 128'(1));
            if (c == 268) chk("t3_busy", 128'(busy), 128'(1));
        end
        tvalid = 1'b0;
        chk("t3_done", 128'(done), 128'(1));
        drain("t3");
        chk("t3_ovf_sticky", 128'(overflow_error), 128'(1));

        // 5: flush together with arm while full
        do_arm(600, 64, 599);
        for (int c = 600; c <= 663; c++) begin
            counter = 64'(c); tvalid = 1'b1; tdata = mk(c);
            tick();
        end
        tvalid = 1'b0;
        chk("t5_full", 128'(full), 128'(1));
        flush = 1'b1; arm = 1'b1; start_time = 64'd700; sample_count = 16'd5; counter = 64'd650;
        tick();
        flush = 1'b0; arm = 1'b0;
        chk("t5_rd_valid", 128'(rd_valid), 128'(0));
        chk("t5_full_clr", 128'(full), 128'(0));
        chk("t5_ovf_clr", 128'(overflow_error), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_state", 128'(fsm_state), 128'(0));

        // rd_ready on an empty buffer has no effect on the half selector
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;

        // 4: gaps in tvalid; cycles are counted, not beats
        do_arm(300, 4, 299);
        for (int c = 300; c <= 303; c++) begin
            counter = 64'(c); tdata = mk(c);
            tvalid = (c == 301 || c == 303);
            if (c == 301 || c == 303) push_beat(c);
            tick();
            if (c == 302) chk("t4_done_early", 128'(done), 128'(0));
        end
        tvalid = 1'b0;
        chk("t4_done", 128'(done), 128'(1));
        drain("t4");

        // 6: reset in the middle of a capture
        do_arm(400, 10, 399);
        for (int c = 400; c <= 403; c++) begin
            counter = 64'(c); tvalid = 1'b1; tdata = mk(c);
            tick();
        end
        chk("t6_busy_before", 128'(busy), 128'(1));
        chk("t6_valid_before", 128'(rd_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tready", 128'(tready), 128'(0));
        chk("t6_rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("t6_rst_busy", 128'(busy), 128'(0));
        chk("t6_rst_done", 128'(done), 128'(0));
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        do_arm(500, 2, 499);
        for (int c = 500; c <= 502; c++) begin
            counter = 64'(c); tvalid = 1'b1; tdata = mk(c);
            if (c <= 501) push_beat(c);
            tick();
        end
        tvalid = 1'b0;
        chk("t6_done", 128'(done), 128'(1));
        drain("t6");

        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
